modex_encryptor: RTL and testbench
==================================

MODEX_ENCRYPTOR -- requirements
Module: modex_encryptor

Interface
REQ-001 Parameter ARQ, default 16: plaintext/ciphertext word width in bits.
REQ-002 Parameter ADDR, default 18: memory write address width.
REQ-003 Parameter EW, default 11: number of exponent bits processed, LSB first.
REQ-004 Parameter EXP, default 1243: public exponent e; the inverse of private exponent 1927 modulo phi(1349).
REQ-005 Parameter MOD, default 1349: modulus n; MOD < 2^ARQ.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  request to encrypt plain; sampled only in IDLE.
REQ-009 plain  input  ARQ  plaintext m; captured when start is accepted.
REQ-010 base_addr  input  ADDR  first write address; loaded into the address pointer when start is accepted with load_addr=1.
REQ-011 load_addr  input  1  1: reload the address pointer from base_addr on accept; 0: continue from the current pointer.
REQ-012 busy  output  1  high from the cycle after accept until the done cycle, inclusive.
REQ-013 done  output  1  one-cycle pulse at the end of every accepted job.
REQ-014 err  output  1  high with done when plain >= MOD; held until the next accept.
REQ-015 wr_en  output  1  one-cycle memory write strobe.
REQ-016 wr_addr  output  ADDR  write address, valid while wr_en is high.
REQ-017 wr_data  output  ARQ  ciphertext c, valid while wr_en is high.
REQ-018 cipher  output  2*ARQ  last ciphertext, zero-extended; held until the next done.

Function
REQ-019 The block shall compute c = plain^EXP mod MOD by right-to-left square-and-multiply over exponent bits 0..EW-1.
REQ-020 FSM states shall be IDLE, LOAD, MUL, UPD, WRITE; no other reachable state.
REQ-021 IDLE->LOAD when start=1; LOAD sets res=1, base=plain, bit index=0, and then enters MUL, or enters WRITE when plain >= MOD.
REQ-022 MUL shall last exactly ARQ cycles and shall compute, in parallel, p1 = res*base mod MOD and p2 = base*base mod MOD by interleaved shift-add.
- Per step, MSB first: acc = 2*acc, subtract MOD if acc >= MOD; if multiplier bit = 1, acc = acc + multiplicand, subtract MOD if acc >= MOD.
REQ-023 Multiplier intermediate values shall be at least ARQ+2 bits wide so that no overflow occurs for MOD < 2^ARQ.
REQ-024 UPD (1 cycle) shall update base = p2 and, if EXP bit[index] = 1, res = p1.
- It then increments index and returns to MUL, or goes to WRITE after index EW-1.
REQ-025 WRITE (1 cycle) shall assert done=1 and, if err=0, also assert wr_en=1 with wr_addr = pointer and wr_data = res.
- On a non-error write, cipher is updated and the pointer is incremented; WRITE then returns to IDLE.
REQ-026 If start is accepted at edge k, done shall be high in cycle k+2+EW*(ARQ+1), which is cycle k+189 at the defaults.
REQ-027 An err job shall assert done in cycle k+2 with wr_en=0; cipher and the pointer shall be unchanged.
REQ-028 start while busy=1 shall be ignored; it is neither queued nor allowed to alter operands.
REQ-029 start=1 held through the WRITE cycle shall be accepted in the following IDLE cycle, giving one job per 2+EW*(ARQ+1)+1 cycles.
REQ-030 The address pointer shall wrap from 2^ADDR-1 to 0.
REQ-031 plain=0 shall give c=0, and plain=1 shall give c=1; these are normal jobs with full latency.

Reset
REQ-032 rst=0 shall force the FSM to IDLE immediately, independent of clk.
REQ-033 rst=0 shall clear busy, done, err, wr_en, wr_addr pointer, wr_data, cipher and all datapath registers to 0.
REQ-034 Reset during MUL, UPD or WRITE shall abort the job with no wr_en pulse, including after rst is released.
REQ-035 The first start shall be accepted no earlier than the first rising edge after rst returns high.

Verification
REQ-036 Defaults, load_addr=1, base_addr=0x00010, plain=1348 -> done at k+189, wr_en with wr_addr=0x00010 and wr_data=1348, cipher=0x00000544.
REQ-037 EXP=3, MOD=33, EW=2, plain=4 -> wr_data=31; next job plain=2 with load_addr=0 -> wr_data=8 at wr_addr=base+1.
REQ-038 Defaults, plain=1349 -> done and err at k+2, no wr_en, cipher unchanged; next valid job clears err.
REQ-039 Round trip: random plain < 1349 -> wr_data equals a reference model; feeding the result through exponent 1927 mod 1349 recovers plain.
REQ-040 base_addr=0x3FFFF, two back-to-back jobs (start held high) -> writes at 0x3FFFF then 0x00000, with exactly one idle cycle between jobs.
REQ-041 rst pulsed low mid-MUL -> busy drops immediately, no wr_en ever appears, and a new start completes with the correct value.

Source files
------------

// File: rtl/modex_encryptor.sv
// Modular-exponentiation encryptor: c = plain^EXP mod MOD, computed by
// right-to-left square-and-multiply, with each modular product formed by
// an interleaved shift-add multiplier. The two products of one exponent
// bit (res*base and base*base) are built side by side, one multiplier bit
// per cycle. Each ciphertext is written to a memory port at an
// auto-incrementing address.
module modex_encryptor #(
  parameter int ARQ  = 16,
  parameter int ADDR = 18,
  parameter int EW   = 11,
  parameter int EXP  = 1243,
  parameter int MOD  = 1349
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ARQ-1:0]    plain,
  input  logic [ADDR-1:0]   base_addr,
  input  logic              load_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wr_en,
  output logic [ADDR-1:0]   wr_addr,
  output logic [ARQ-1:0]    wr_data,
  output logic [2*ARQ-1:0]  cipher
);

  // Two guard bits: 2*acc + multiplicand stays below 2*MOD < 2^(ARQ+1).
  localparam int AW = ARQ + 2;
  localparam int SW = $clog2(ARQ);
  localparam int IW = (EW > 1) ? $clog2(EW) : 1;

  localparam logic [AW-1:0] MOD_W     = AW'(MOD);
  localparam logic [EW-1:0] EXP_BITS  = EW'(EXP);
  localparam logic [SW-1:0] STEP_LAST = SW'(ARQ - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(EW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_UPD,
    S_WRITE
  } state_t;

  state_t          state;
  logic [ARQ-1:0]  m_reg;
  logic [ARQ-1:0]  res;
  logic [ARQ-1:0]  base;
  logic [AW-1:0]   acc1;
  logic [AW-1:0]   acc2;
  logic [SW-1:0]   step;
  logic [IW-1:0]   idx;
  logic [ADDR-1:0] ptr;

  logic [AW-1:0]   acc1_nxt;
  logic [AW-1:0]   acc2_nxt;
  logic [ARQ-1:0]  res_upd;

  // One shift-add step: double and reduce, then add the multiplicand if the
  // multiplier bit is set and reduce again. The accumulator stays below MOD.
  function automatic logic [AW-1:0] mod_step(input logic [AW-1:0]  acc,
                                             input logic           mbit,
                                             input logic [ARQ-1:0] mcand);
    logic [AW-1:0] t;
    t = {acc[AW-2:0], 1'b0};
    if (t >= MOD_W) t = t - MOD_W;
    if (mbit) begin
      t = t + {2'b00, mcand};
      if (t >= MOD_W) t = t - MOD_W;
    end
    return t;
  endfunction

  // Next multiplier states and the conditional result update for this bit.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    acc1_nxt = mod_step(acc1, res[step], base);
    acc2_nxt = mod_step(acc2, base[step], base);
    res_upd  = res;
    if (EXP_BITS[idx]) res_upd = acc1[ARQ-1:0];
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: every register, datapath included, is cleared here so an
      // aborted job leaves no stale operands or write behind.
      state   <= S_IDLE;
      m_reg   <= '0;
      res     <= '0;
      base    <= '0;
      acc1    <= '0;
      acc2    <= '0;
      step    <= '0;
      idx     <= '0;
      ptr     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      cipher  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      done  <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            m_reg <= plain;
            err   <= 1'b0;
            busy  <= 1'b1;
            if (load_addr) ptr <= base_addr;
            state <= S_LOAD;
          end
        end

        S_LOAD: begin
          res  <= ARQ'(1);
          base <= m_reg;
          idx  <= '0;
          step <= STEP_LAST;
          acc1 <= '0;
          acc2 <= '0;
          if ({2'b00, m_reg} >= MOD_W) begin
            // Out-of-range plaintext: report and skip straight to the end.
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_WRITE;
          end else begin
            state <= S_MUL;
          end
        end

        S_MUL: begin
          acc1 <= acc1_nxt;
          acc2 <= acc2_nxt;
          step <= step - 1'b1;
          if (step == '0) state <= S_UPD;
        end

        S_UPD: begin
          base <= acc2[ARQ-1:0];
          res  <= res_upd;
          acc1 <= '0;
          acc2 <= '0;
          step <= STEP_LAST;
          if (idx == IDX_LAST) begin
            // Last exponent bit: the write is registered on entry to WRITE.
            done    <= 1'b1;
            wr_en   <= 1'b1;
            wr_addr <= ptr;
            wr_data <= res_upd;
            cipher  <= {{ARQ{1'b0}}, res_upd};
            ptr     <= ptr + 1'b1;
            state   <= S_WRITE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_MUL;
          end
        end

        S_WRITE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modex_encryptor.sv
// Self-checking bench for modex_encryptor: a vector table of jobs on the
// default instance, scoreboarded by a done-cycle monitor, plus hand-written
// sequences for back-to-back jobs, reset abort, busy-start rejection and a
// second small-parameter instance.
module tb_modex_encryptor;

  localparam int LAT     = 189;
  localparam int LAT_ERR = 2;
  localparam int PERIOD  = 190;

  typedef struct {
    logic [15:0] plain;
    logic        load;
    logic [17:0] base;
    logic [15:0] exp_data;
  } vec_t;

  typedef struct {
    logic [15:0] plain;
    logic        err;
    logic [17:0] addr;
    logic [15:0] data;
    logic [31:0] cipher;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] plain_i = '0;
  logic [17:0] base_i = '0;
  logic        load_i = 1'b0;
  logic        busy, done, err, wr_en;
  logic [17:0] wr_addr;
  logic [15:0] wr_data;
  logic [31:0] cipher;

  logic        start2 = 1'b0;
  logic [15:0] plain2 = '0;
  logic [17:0] base2 = '0;
  logic        load2 = 1'b0;
  logic        busy2, done2, err2, wr_en2;
  logic [17:0] wr_addr2;
  logic [15:0] wr_data2;
  logic [31:0] cipher2;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   wr_seen = 0;
  int   acc_q[$];
  int   acc_hist[$];
  exp_t exp_q[$];

  logic [17:0] ptr_m = '0;
  logic [31:0] cip_m = '0;

  modex_encryptor dut (
    .clk(clk), .rst(rst_n), .start(start), .plain(plain_i),
    .base_addr(base_i), .load_addr(load_i), .busy(busy), .done(done),
    .err(err), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cipher(cipher)
  );

  modex_encryptor #(.ARQ(16), .ADDR(18), .EW(2), .EXP(3), .MOD(33)) dut2 (
    .clk(clk), .rst(rst_n), .start(start2), .plain(plain2),
    .base_addr(base2), .load_addr(load2), .busy(busy2), .done(done2),
    .err(err2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .cipher(cipher2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic longint modpow(input longint b, input longint e,
                                    input longint m);
    longint r = 1;
    longint x = b % m;
    longint k = e;
    while (k > 0) begin
      if (k[0]) r = (r * x) % m;
      x = (x * x) % m;
      k = k >>> 1;
    end
    return r;
  endfunction

  // Accept edges: the DUT is idle exactly when busy is low.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && start && !busy) begin
      acc_q.push_back(cyc);
      acc_hist.push_back(cyc);
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wr_seen++;
        check("done_with_wr_en", done, 1);
      end
      if (done) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          exp_t e;
          int   k;
          e = exp_q.pop_front();
          k = acc_q.pop_front();
          check("latency", cyc + 1 - k, e.lat);
          check("err", err, e.err);
          check("wr_en", wr_en, !e.err);
          check("busy_at_done", busy, 1);
          check("cipher", cipher, e.cipher);
          if (!e.err) begin
            check("wr_addr", wr_addr, e.addr);
            check("wr_data", wr_data, e.data);
            check("round_trip", modpow(wr_data, 1927, 1349), e.plain);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) check("idle_timeout", exp_q.size(), 0);
  endtask

  task automatic push_exp(input logic [15:0] p, input logic ld,
                          input logic [17:0] b, input logic [15:0] d);
    exp_t e;
    e.plain = p;
    e.err   = (p >= 16'd1349);
    e.lat   = e.err ? LAT_ERR : LAT;
    e.addr  = '0;
    e.data  = '0;
    if (ld) ptr_m = b;
    if (!e.err) begin
      e.addr = ptr_m;
      e.data = d;
      cip_m  = {16'h0, d};
      ptr_m  = ptr_m + 1'b1;
    end
    e.cipher = cip_m;
    exp_q.push_back(e);
  endtask

  task automatic issue_job(input logic [15:0] p, input logic ld,
                           input logic [17:0] b, input logic [15:0] d);
    wait_idle();
    push_exp(p, ld, b, d);
    plain_i = p;
    load_i  = ld;
    base_i  = b;
    start   = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    load_i = 1'b0;
  endtask

  task automatic run_small(input logic [15:0] p, input logic ld,
                           input logic [17:0] b, input logic [15:0] d,
                           input logic [17:0] a);
    int n = 1;
    plain2 = p;
    load2  = ld;
    base2  = b;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    load2  = 1'b0;
    while (!done2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("small_latency", n, 36);
    check("small_wr_en", wr_en2, 1);
    check("small_wr_data", wr_data2, d);
    check("small_wr_addr", wr_addr2, a);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    int   n0;
    int   n;
    logic [15:0] pa, pb;

    vecs[0] = '{16'd1348,  1'b1, 18'h00010, 16'd1348};
    vecs[1] = '{16'd0,     1'b0, 18'h0,     16'd0};
    vecs[2] = '{16'd1,     1'b0, 18'h0,     16'd1};
    vecs[3] = '{16'd1349,  1'b0, 18'h0,     16'd0};
    vecs[4] = '{16'd2,     1'b0, 18'h0,     16'(modpow(2, 1243, 1349))};
    vecs[5] = '{16'hFFFF,  1'b0, 18'h0,     16'd0};
    vecs[6] = '{16'd1000,  1'b1, 18'h00200, 16'(modpow(1000, 1243, 1349))};
    for (int i = 7; i < 10; i++) begin
      logic [15:0] r;
      r = 16'($urandom_range(2, 1347));
      vecs[i] = '{r, 1'b0, 18'h0, 16'(modpow(r, 1243, 1349))};
    end

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_cipher", cipher, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Small-parameter instance: 4^3 mod 33 then 2^3 mod 33 at base+1.
    run_small(16'd4, 1'b1, 18'h00100, 16'd31, 18'h00100);
    run_small(16'd2, 1'b0, 18'h0,     16'd8,  18'h00101);

    // Vector table on the default instance.
    for (int i = 0; i < 10; i++) begin
      issue_job(vecs[i].plain, vecs[i].load, vecs[i].base, vecs[i].exp_data);
      if (vecs[i].plain >= 16'd1349) begin
        wait_idle();
        @(negedge clk);
        check("err_held", err, 1);
        check("err_cipher_held", cipher, cip_m);
      end
    end
    wait_idle();

    // start pulsed while busy must be ignored.
    pa = 16'd123;
    issue_job(pa, 1'b0, 18'h0, 16'(modpow(pa, 1243, 1349)));
    repeat (20) @(negedge clk);
    plain_i = 16'd5;
    load_i  = 1'b1;
    base_i  = 18'h00333;
    start   = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    load_i = 1'b0;
    wait_idle();

    // Back-to-back with start held: pointer wraps from 0x3FFFF to 0.
    pa = 16'($urandom_range(2, 1347));
    pb = 16'($urandom_range(2, 1347));
    wait_idle();
    n0 = acc_hist.size();
    push_exp(pa, 1'b1, 18'h3FFFF, 16'(modpow(pa, 1243, 1349)));
    push_exp(pb, 1'b0, 18'h0,     16'(modpow(pb, 1243, 1349)));
    plain_i = pa;
    load_i  = 1'b1;
    base_i  = 18'h3FFFF;
    start   = 1'b1;
    @(negedge clk);
    plain_i = pb;
    load_i  = 1'b0;
    n = 0;
    while (acc_hist.size() < n0 + 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("b2b_accepts", acc_hist.size(), n0 + 2);
    if (acc_hist.size() >= n0 + 2)
      check("b2b_period", acc_hist[n0+1] - acc_hist[n0], PERIOD);
    wait_idle();

    // Reset mid-MUL aborts the job with no write.
    issue_job(16'd77, 1'b1, 18'h00050, 16'(modpow(77, 1243, 1349)));
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_cipher", cipher, 0);
    exp_q.delete();
    acc_q.delete();
    ptr_m = '0;
    cip_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    n0 = wr_seen;
    repeat (250) @(negedge clk);
    check("abort_no_write", wr_seen - n0, 0);
    issue_job(16'd77, 1'b0, 18'h0, 16'(modpow(77, 1243, 1349)));
    wait_idle();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
